control_unit: RTL and testbench
===============================

# control_unit

Multicycle fetch/decode/execute/writeback sequencer for the 16-bit simple RISC CPU. It sits directly upstream of the `alu`. It fetches instructions over a valid-qualified port, decodes them, and drives the ALU's `ALUControl`, the register-file read/write addresses and write strobe, and the immediate operand mux. It also owns the program counter and handles branch, jump and halt.

## Interface
- `PC_WIDTH`, 8, program counter / instruction address width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `instr_addr`  out  PC_WIDTH  current PC, presented to instruction memory
- `instr_req`  out  1  fetch request, high only in FETCH
- `instr_data`  in  16  instruction word
- `instr_valid`  in  1  `instr_data` valid this cycle
- `alu_zero`  in  1  ALU `Result == 0`, sampled in EXECUTE
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  3  register-file addresses
- `ALUControl`  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV
- `alu_src_imm`  out  1  1 selects `imm` as ALU B operand instead of rs2
- `imm`  out  16  sign-extended immediate
- `reg_write`  out  1  register-file write strobe, one cycle per writing instruction
- `halted`  out  1  sticky, set by HALT
- `illegal`  out  1  one-cycle pulse on an undefined opcode

## Operation
- Instruction format: opcode [15:12], rd [11:9], rs1 [8:6], rs2 [5:3], imm6 [5:0], imm12 [11:0].
- Opcodes 0x0–0x5 are R-type ALU ops; `ALUControl` = opcode[2:0]; rd ← rs1 op rs2.
- 0x6 ADDI: rd ← rs1 + sext(imm6). `ALUControl`=000, `alu_src_imm`=1.
- 0x7 BEQ: `ALUControl`=001 on rs1, rs2. If `alu_zero`, PC ← PC + 1 + sext(imm6), else PC+1. No write.
- 0x8 JMP: PC ← imm12 truncated to PC_WIDTH. No write.
- 0xF HALT: enter HALT; `halted`=1.
- 0x9–0xE are illegal: pulse `illegal` in DECODE, then execute as a NOP (PC+1, no write).
- States: FETCH → DECODE → EXECUTE → WRITEBACK → FETCH; HALT is terminal.
  - FETCH: `instr_req`=1. Hold until `instr_valid`. On valid, latch `instr_data` into IR and go to DECODE.
  - DECODE: drive `rs1_addr`/`rs2_addr`/`rd_addr`/`imm` from IR. They stay stable through WRITEBACK.
  - EXECUTE: drive `ALUControl`/`alu_src_imm`. Register the branch decision from `alu_zero`.
  - WRITEBACK: `reg_write`=1 for 0x0–0x6. Update PC. Return to FETCH, or go to HALT for 0xF.
- PC arithmetic is modulo 2^PC_WIDTH; it wraps from max to 0 and on negative offsets.
- `ALUControl` holds its last value outside EXECUTE/WRITEBACK. `alu_src_imm`=0 for non-ADDI instructions.
- The block never writes register 0 specially; r0 behaviour belongs to the register file.

## Timing
- Reset (async, immediate) sets:
  - state FETCH, PC=`RESET_PC`, IR=0
  - `reg_write`=0, `halted`=0, `illegal`=0, `ALUControl`=000, `alu_src_imm`=0, `imm`=0
  - all address outputs = 0
- Normal instruction takes 4 cycles with zero fetch wait. Each FETCH cycle without `instr_valid` adds one cycle.
- `instr_valid` is ignored outside FETCH.
- `reg_write` asserts in exactly one cycle (WRITEBACK). The new PC is visible on `instr_addr` in the following FETCH.
- HALT: `instr_req`=0 and `reg_write`=0 forever. Only reset leaves HALT.
- Reset mid-instruction abandons the instruction: no write, PC=`RESET_PC`.

## Test plan
- Reset, then fetch 0x0A50 (ADD r5←r1+r2) with `instr_valid` on first FETCH cycle → `rs1_addr`=1, `rs2_addr`=2, `rd_addr`=5, `ALUControl`=000; `reg_write` high only in cycle 4; `instr_addr` 0→1.
- Issue SUB, AND, OR, MUL, DIV (opcodes 1–5) → `ALUControl` 001, 010, 011, 100, 101 respectively, one `reg_write` pulse each.
- ADDI rd=3, rs1=1, imm6=0x3F → `imm`=0xFFFF, `alu_src_imm`=1, `reg_write` once.
- BEQ at PC=10, imm6=0x3E (−2): with `alu_zero`=1 → next PC 9; with `alu_zero`=0 → next PC 11. Also JMP 0x0FF at PC_WIDTH=8 → PC=0xFF, then PC+1 wraps to 0.
- Hold `instr_valid`=0 for 3 cycles in FETCH → no state advance, PC stable. Then fetch 0x9000 → `illegal` one-cycle pulse, no write, PC+1.
- Fetch 0xF000 → `halted`=1 and no further `instr_req`. Separately, assert `reset` during EXECUTE of an ADD → no `reg_write`, PC=`RESET_PC`, state FETCH.

Source files
------------

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Multicycle FETCH -> DECODE -> EXECUTE -> WRITEBACK sequencer for the 16-bit
//   simple RISC CPU. It owns the PC and the instruction register, and drives
//   the ALU op, register-file addresses and write strobe, and the immediate
//   operand mux. HALT is terminal; only reset leaves it.
//
//   Ports
//     clk, reset          clock, async active-high reset
//     instr_addr/req      fetch address (PC) and request (FETCH only)
//     instr_data/valid    fetched word, qualified by valid (FETCH only)
//     alu_zero            ALU zero flag, sampled at the end of EXECUTE
//     rs1/rs2/rd_addr     register-file addresses, stable DECODE..WRITEBACK
//     ALUControl          ALU op, updated entering EXECUTE
//     alu_src_imm         ALU B operand select (imm) for ADDI
//     imm                 sign-extended immediate
//     reg_write           one-cycle write strobe in WRITEBACK
//     halted              sticky halt flag
//     illegal             one-cycle pulse in DECODE on opcodes 0x9..0xE
// -----------------------------------------------------------------------------
module control_unit #(
   parameter int                     PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   output logic [PC_WIDTH-1:0] instr_addr,
   output logic                instr_req,
   input  logic [15:0]         instr_data,
   input  logic                instr_valid,
   input  logic                alu_zero,
   output logic [2:0]          rs1_addr,
   output logic [2:0]          rs2_addr,
   output logic [2:0]          rd_addr,
   output logic [2:0]          ALUControl,
   output logic                alu_src_imm,
   output logic [15:0]         imm,
   output logic                reg_write,
   output logic                halted,
   output logic                illegal
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_ADDI = 4'h6;
   localparam logic [3:0] OP_BEQ  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t              state_q;
   logic [15:0]         ir_q;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [2:0]          rs1_q, rs2_q, rd_q, alu_ctl_q;
   logic [15:0]         imm_q;
   logic                src_imm_q, reg_write_q, halted_q, illegal_q, take_q;

   logic [3:0]          ir_op, in_op;
   logic [PC_WIDTH-1:0] br_off;

   assign ir_op  = ir_q[15:12];
   assign in_op  = instr_data[15:12];
   // imm6 sign-extended to PC width; PC arithmetic wraps naturally.
   assign br_off = PC_WIDTH'($signed(ir_q[5:0]));

   always_comb begin
      pc_d = pc_q + PC_WIDTH'(1);
      if (ir_op == OP_BEQ && take_q)
         pc_d = pc_q + PC_WIDTH'(1) + br_off;
      else if (ir_op == OP_JMP)
         pc_d = PC_WIDTH'(ir_q[11:0]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FETCH;
         ir_q        <= '0;
         pc_q        <= RESET_PC;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         alu_ctl_q   <= '0;
         src_imm_q   <= 1'b0;
         reg_write_q <= 1'b0;
         halted_q    <= 1'b0;
         illegal_q   <= 1'b0;
         take_q      <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (instr_valid) begin
                  // Decode fields are captured with the IR so they are
                  // already valid during the DECODE cycle.
                  ir_q      <= instr_data;
                  rs1_q     <= instr_data[8:6];
                  rs2_q     <= instr_data[5:3];
                  rd_q      <= instr_data[11:9];
                  imm_q     <= (in_op == OP_JMP) ? {{4{instr_data[11]}}, instr_data[11:0]}
                                                 : {{10{instr_data[5]}}, instr_data[5:0]};
                  illegal_q <= (in_op inside {[4'h9:4'hE]});
                  state_q   <= S_DECODE;
               end
            end
            S_DECODE: begin
               illegal_q <= 1'b0;
               // Only ALU-using ops touch ALUControl; others leave it held.
               if (ir_op <= OP_ADDI)
                  alu_ctl_q <= (ir_op == OP_ADDI) ? 3'b000 : ir_op[2:0];
               else if (ir_op == OP_BEQ)
                  alu_ctl_q <= 3'b001;
               src_imm_q <= (ir_op == OP_ADDI);
               state_q   <= S_EXEC;
            end
            S_EXEC: begin
               take_q      <= alu_zero;
               reg_write_q <= (ir_op <= OP_ADDI);
               state_q     <= S_WB;
            end
            S_WB: begin
               reg_write_q <= 1'b0;
               src_imm_q   <= 1'b0;
               if (ir_op == OP_HALT) begin
                  halted_q <= 1'b1;
                  state_q  <= S_HALT;
               end else begin
                  pc_q    <= pc_d;
                  state_q <= S_FETCH;
               end
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign instr_addr  = pc_q;
   assign instr_req   = (state_q == S_FETCH);
   assign rs1_addr    = rs1_q;
   assign rs2_addr    = rs2_q;
   assign rd_addr     = rd_q;
   assign ALUControl  = alu_ctl_q;
   assign alu_src_imm = src_imm_q;
   assign imm         = imm_q;
   assign reg_write   = reg_write_q;
   assign halted      = halted_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] instr_addr;
   logic          instr_req;
   logic [15:0]   instr_data;
   logic          instr_valid;
   logic          alu_zero;
   logic [2:0]    rs1_addr, rs2_addr, rd_addr, ALUControl;
   logic          alu_src_imm;
   logic [15:0]   imm;
   logic          reg_write, halted, illegal;

   control_unit #(.PC_WIDTH(PW), .RESET_PC(8'd0)) dut (
      .clk(clk), .reset(reset),
      .instr_addr(instr_addr), .instr_req(instr_req),
      .instr_data(instr_data), .instr_valid(instr_valid),
      .alu_zero(alu_zero),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .ALUControl(ALUControl), .alu_src_imm(alu_src_imm), .imm(imm),
      .reg_write(reg_write), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Per-instruction observations, one snapshot per state.
   logic [2:0]    c_rs1, c_rs2, c_rd, c_alu;
   logic [15:0]   c_imm;
   logic          c_src, c_ill_d, c_ill_e;
   logic          c_rw_d, c_rw_e, c_rw_w, c_rw_n;
   logic [PW-1:0] c_pc_f, c_pc_n;
   logic          c_req_n, c_halt_n;

   // Call at a negedge with the DUT in FETCH.
   task automatic run(input logic [15:0] ins, input logic z, input int stall);
      c_pc_f = instr_addr;
      for (int i = 0; i < stall; i++) begin
         instr_valid = 1'b0;
         instr_data  = 16'hFFFF;
         @(negedge clk);
         check("stall_pc", instr_addr, c_pc_f);
         check("stall_req", instr_req, 1);
      end
      instr_data  = ins;
      instr_valid = 1'b1;
      @(negedge clk);
      c_rs1 = rs1_addr; c_rs2 = rs2_addr; c_rd = rd_addr; c_imm = imm;
      c_ill_d = illegal; c_rw_d = reg_write;
      // Keep valid high with a HALT word: must be ignored outside FETCH.
      instr_data = 16'hF000;
      alu_zero   = z;
      @(negedge clk);
      c_alu = ALUControl; c_src = alu_src_imm; c_ill_e = illegal; c_rw_e = reg_write;
      @(negedge clk);
      c_rw_w = reg_write;
      instr_valid = 1'b0;
      alu_zero    = 1'b0;
      @(negedge clk);
      c_pc_n = instr_addr; c_rw_n = reg_write; c_req_n = instr_req; c_halt_n = halted;
   endtask

   initial begin
      logic [3:0] o;
      reset = 1'b1; instr_valid = 1'b0; instr_data = 16'h0; alu_zero = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pc", instr_addr, 0);
      check("rst_req", instr_req, 1);
      check("rst_rw", reg_write, 0);
      check("rst_halt", halted, 0);
      check("rst_ill", illegal, 0);
      check("rst_alu", ALUControl, 0);
      check("rst_src", alu_src_imm, 0);
      check("rst_imm", imm, 0);
      check("rst_addrs", {rs1_addr, rs2_addr, rd_addr}, 0);
      reset = 1'b0;

      // ADD r5 <- r1 + r2
      run(16'h0A50, 1'b0, 0);
      check("add_pc0", c_pc_f, 0);
      check("add_rs1", c_rs1, 1);
      check("add_rs2", c_rs2, 2);
      check("add_rd", c_rd, 5);
      check("add_alu", c_alu, 0);
      check("add_rw", {c_rw_d, c_rw_e, c_rw_w, c_rw_n}, 4'b0010);
      check("add_pc1", c_pc_n, 1);

      // SUB..DIV, rd = opcode
      for (int op = 1; op <= 5; op++) begin
         o = 4'(op);
         run({o, o[2:0], 3'd1, 3'd2, 3'd0}, 1'b0, 0);
         check("rop_alu", c_alu, o[2:0]);
         check("rop_rd", c_rd, o[2:0]);
         check("rop_rw", {c_rw_d, c_rw_e, c_rw_w, c_rw_n}, 4'b0010);
         check("rop_pc", c_pc_n, op + 1);
      end

      // JMP 10: ALUControl must hold DIV's 101
      run(16'h800A, 1'b0, 0);
      check("jmp_alu_hold", c_alu, 3'b101);
      check("jmp_rw", {c_rw_d, c_rw_e, c_rw_w, c_rw_n}, 4'b0000);
      check("jmp_pc", c_pc_n, 10);

      // ADDI r3 <- r1 + sext(0x3F)
      run(16'h667F, 1'b0, 0);
      check("addi_imm", c_imm, 16'hFFFF);
      check("addi_src", c_src, 1);
      check("addi_alu", c_alu, 0);
      check("addi_rd", c_rd, 3);
      check("addi_rw", {c_rw_d, c_rw_e, c_rw_w, c_rw_n}, 4'b0010);
      check("addi_pc", c_pc_n, 11);

      // BEQ at PC=10, offset -2, taken -> 9
      run(16'h800A, 1'b0, 0);
      run(16'h707E, 1'b1, 0);
      check("beq_alu", c_alu, 3'b001);
      check("beq_src", c_src, 0);
      check("beq_rs", {c_rs1, c_rs2}, {3'd1, 3'd7});
      check("beq_rw", {c_rw_d, c_rw_e, c_rw_w, c_rw_n}, 4'b0000);
      check("beq_t_pc", c_pc_n, 9);
      // not taken -> 11
      run(16'h800A, 1'b0, 0);
      run(16'h707E, 1'b0, 0);
      check("beq_nt_pc", c_pc_n, 11);

      // JMP 0xFF then wrap to 0
      run(16'h80FF, 1'b0, 0);
      check("jmpff_pc", c_pc_n, 8'hFF);
      run(16'h0A50, 1'b0, 0);
      check("wrap_pc", c_pc_n, 0);

      // 3 stall cycles then illegal opcode
      run(16'h9000, 1'b0, 3);
      check("ill_pulse", {c_ill_d, c_ill_e}, 2'b10);
      check("ill_rw", {c_rw_d, c_rw_e, c_rw_w, c_rw_n}, 4'b0000);
      check("ill_pc", c_pc_n, 1);

      // Reset during EXECUTE of an ADD at PC=1
      instr_data = 16'h0A50; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_rw", reg_write, 0);
      check("mid_rst_pc", instr_addr, 0);
      check("mid_rst_req", instr_req, 1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_rw", reg_write, 0);
      check("post_rst_req", instr_req, 1);
      check("post_rst_pc", instr_addr, 0);

      // HALT
      run(16'hF000, 1'b0, 0);
      check("halt_flag", c_halt_n, 1);
      check("halt_req", c_req_n, 0);
      check("halt_rw", c_rw_w, 0);
      instr_data = 16'h0A50; instr_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("halt_stay_req", instr_req, 0);
      check("halt_stay_rw", reg_write, 0);
      check("halt_stay", halted, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
